// File: rtl/tmds_encode.sv
// TMDS 8b/10b lane encoder: video (DC-balanced), control, TERC4 and guard-band symbols.
// Two register stages: stage 1 holds the transition-minimised word, stage 2 balances it and drives out.
module tmds_encode #(
  parameter int CHANNEL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [7:0] data,
  input  logic [1:0] sync,
  input  logic [3:0] ctrl,
  output logic [9:0] out
);

  localparam logic [1:0] MODE_CTRL  = 2'd0;
  localparam logic [1:0] MODE_VIDEO = 2'd1;
  localparam logic [1:0] MODE_TERC4 = 2'd2;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] GUARD   = (CHANNEL == 1) ? 10'b0100110011 : 10'b1011001100;

  function automatic logic [9:0] ctrl_code(input logic [1:0] s);
    case (s)
      2'b00:   ctrl_code = 10'b1101010100;
      2'b01:   ctrl_code = 10'b0010101011;
      2'b10:   ctrl_code = 10'b0101010100;
      default: ctrl_code = 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] terc4_code(input logic [3:0] c);
    case (c)
      4'h0:    terc4_code = 10'b1010011100;
      4'h1:    terc4_code = 10'b1001100011;
      4'h2:    terc4_code = 10'b1011100100;
      4'h3:    terc4_code = 10'b1011100010;
      4'h4:    terc4_code = 10'b0101110001;
      4'h5:    terc4_code = 10'b0100011110;
      4'h6:    terc4_code = 10'b0110001110;
      4'h7:    terc4_code = 10'b0100111100;
      4'h8:    terc4_code = 10'b1011001100;
      4'h9:    terc4_code = 10'b0100111001;
      4'hA:    terc4_code = 10'b0110011100;
      4'hB:    terc4_code = 10'b1011000110;
      4'hC:    terc4_code = 10'b1010001110;
      4'hD:    terc4_code = 10'b1001110001;
      4'hE:    terc4_code = 10'b0101100011;
      default: terc4_code = 10'b1011000011;
    endcase
  endfunction

  // Stage 1 combinational: transition minimisation
  logic [3:0] d_n1;
  logic       use_xnor;
  logic [8:0] qm;
  logic [3:0] qm_n1;

  always_comb begin
    logic [8:0] t;
    d_n1     = 4'($countones(data));
    use_xnor = (d_n1 > 4'd4) || ((d_n1 == 4'd4) && !data[0]);
    t        = '0;
    t[0]     = data[0];
    for (int i = 1; i < 8; i++) begin
      t[i] = use_xnor ? ~(t[i-1] ^ data[i]) : (t[i-1] ^ data[i]);
    end
    t[8]  = ~use_xnor;
    qm    = t;
    qm_n1 = 4'($countones(t[7:0]));
  end

  // Stage 1 registers; reset state represents a control symbol with sync=00
  logic [1:0] s1_mode;
  logic [1:0] s1_sync;
  logic [3:0] s1_ctrl;
  logic [8:0] s1_qm;
  logic [3:0] s1_n1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_mode <= MODE_CTRL;
      s1_sync <= 2'b00;
      s1_ctrl <= 4'h0;
      s1_qm   <= '0;
      s1_n1   <= '0;
    end else begin
      s1_mode <= mode;
      s1_sync <= sync;
      s1_ctrl <= ctrl;
      s1_qm   <= qm;
      s1_n1   <= qm_n1;
    end
  end

  // Stage 2 combinational: DC balancing against running disparity cnt
  logic signed [4:0] cnt;
  logic signed [4:0] nxt_cnt;
  logic signed [4:0] bal;
  logic [9:0]        nxt_out;
  logic              q8;
  logic [7:0]        q7;

  // bal = n1 - n0 = 2*n1 - 8 (the 5-bit wrap of 2*8 cancels out)
  assign bal = $signed({s1_n1, 1'b0}) - 5'sd8;
  assign q8  = s1_qm[8];
  assign q7  = s1_qm[7:0];

  always_comb begin
    nxt_out = CTRL_00;
    nxt_cnt = '0;
    case (s1_mode)
      MODE_CTRL: nxt_out = ctrl_code(s1_sync);
      MODE_VIDEO: begin
        if ((cnt == 0) || (bal == 0)) begin
          nxt_out = {~q8, q8, q8 ? q7 : ~q7};
          nxt_cnt = q8 ? (cnt + bal) : (cnt - bal);
        end else if (((cnt > 0) && (bal > 0)) || ((cnt < 0) && (bal < 0))) begin
          nxt_out = {1'b1, q8, ~q7};
          nxt_cnt = cnt + (q8 ? 5'sd2 : 5'sd0) - bal;
        end else begin
          nxt_out = {1'b0, q8, q7};
          nxt_cnt = cnt + bal - (q8 ? 5'sd0 : 5'sd2);
        end
      end
      MODE_TERC4: nxt_out = terc4_code(s1_ctrl);
      default:    nxt_out = GUARD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= CTRL_00;
      cnt <= '0;
    end else begin
      out <= nxt_out;
      cnt <= nxt_cnt;
    end
  end

endmodule

// File: tb/tb_tmds_encode.sv
// Bench for tmds_encode: three lanes (CHANNEL 0/1/2) on shared inputs, scoreboard fed by a
// behavioural model of the encoding rules, popped by a monitor two cycles after each symbol.
module tb_tmds_encode;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [7:0] data = 8'h00;
  logic [1:0] sync = 2'd0;
  logic [3:0] ctrl = 4'h0;
  logic [9:0] out0, out1, out2;

  tmds_encode #(.CHANNEL(0)) dut0 (.clk(clk), .reset(reset), .mode(mode), .data(data),
                                   .sync(sync), .ctrl(ctrl), .out(out0));
  tmds_encode #(.CHANNEL(1)) dut1 (.clk(clk), .reset(reset), .mode(mode), .data(data),
                                   .sync(sync), .ctrl(ctrl), .out(out1));
  tmds_encode #(.CHANNEL(2)) dut2 (.clk(clk), .reset(reset), .mode(mode), .data(data),
                                   .sync(sync), .ctrl(ctrl), .out(out2));

  // ---------------- clock / reset-aware valid pipeline ----------------
  always #5 clk = ~clk;

  localparam logic [9:0] CTRL00   = 10'b1101010100;
  localparam logic [9:0] GUARD_02 = 10'b1011001100;
  localparam logic [9:0] GUARD_1  = 10'b0100110011;

  logic [9:0] ctrl_tab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  logic [9:0] terc4_tab [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  int checks = 0;
  int passed = 0;
  int model_cnt = 0;
  int bal_acc = 0;

  // entry = {mode, exp_ch2, exp_ch1, exp_ch0}
  logic [31:0] exp_q[$];
  logic stim_valid = 1'b0;
  logic v1, v2;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= stim_valid;
      v2 <= v1;
    end
  end

  task automatic check10(input string name, input logic [9:0] act, input logic [9:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %b required %b at %0t", name, act, req, $time);
  endtask

  // ---------------- reference model ----------------
  task automatic ref_video(input logic [7:0] d, output logic [9:0] sym);
    int ones_d, n1, n0;
    logic xn;
    logic [8:0] q;
    ones_d = $countones(d);
    xn = (ones_d > 4) || (ones_d == 4 && d[0] == 1'b0);
    q = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~xn;
    n1 = $countones(q[7:0]);
    n0 = 8 - n1;
    if (model_cnt == 0 || n1 == n0) begin
      sym = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      model_cnt += q[8] ? (n1 - n0) : (n0 - n1);
    end else if ((model_cnt > 0 && n1 > n0) || (model_cnt < 0 && n0 > n1)) begin
      sym = {1'b1, q[8], ~q[7:0]};
      model_cnt += (q[8] ? 2 : 0) + (n0 - n1);
    end else begin
      sym = {1'b0, q[8], q[7:0]};
      model_cnt += (n1 - n0) - (q[8] ? 0 : 2);
    end
  endtask

  task automatic expected(input logic [1:0] m, input logic [7:0] d, input logic [1:0] s,
                          input logic [3:0] c, output logic [31:0] e);
    logic [9:0] v;
    case (m)
      2'd0: begin v = ctrl_tab[s]; model_cnt = 0; e = {m, v, v, v}; end
      2'd1: begin ref_video(d, v); e = {m, v, v, v}; end
      2'd2: begin v = terc4_tab[c]; model_cnt = 0; e = {m, v, v, v}; end
      default: begin model_cnt = 0; e = {m, GUARD_02, GUARD_1, GUARD_02}; end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] m, input logic [7:0] d, input logic [1:0] s,
                      input logic [3:0] c);
    logic [31:0] e;
    @(negedge clk);
    mode = m; data = d; sync = s; ctrl = c;
    stim_valid = 1'b1;
    expected(m, d, s, c, e);
    exp_q.push_back(e);
  endtask

  // Directed symbol with a hand-derived expected code; the model still advances its disparity.
  task automatic send_known(input logic [1:0] m, input logic [7:0] d, input logic [1:0] s,
                            input logic [3:0] c, input logic [9:0] k);
    logic [31:0] e;
    @(negedge clk);
    mode = m; data = d; sync = s; ctrl = c;
    stim_valid = 1'b1;
    expected(m, d, s, c, e);
    exp_q.push_back({m, k, k, k});
  endtask

  task automatic pulse_reset(input int hold);
    @(negedge clk);
    #1;
    reset = 1'b1;
    stim_valid = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check10("rst_ch0", out0, CTRL00);
      check10("rst_ch1", out1, CTRL00);
      check10("rst_ch2", out2, CTRL00);
    end
    mode = 2'd0;
    sync = 2'd0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check10("post_rst_ch0", out0, CTRL00);
    check10("post_rst_ch1", out1, CTRL00);
    check10("post_rst_ch2", out2, CTRL00);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        bal_acc = 0;
      end else if (v2) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL scoreboard_empty: output present with no expected entry at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check10("lane0", out0, e[9:0]);
          check10("lane1", out1, e[19:10]);
          check10("lane2", out2, e[29:20]);
          if (e[31:30] == 2'd1) begin
            bal_acc += 2 * $countones(out0) - 10;
            checks++;
            if (bal_acc >= -10 && bal_acc <= 10) passed++;
            else $display("FAIL balance: running disparity %0d required within +/-10", bal_acc);
          end else begin
            bal_acc = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    mode = 2'd1;
    data = 8'hA5;
    pulse_reset(3);

    send_known(2'd0, 8'h00, 2'b11, 4'h0, 10'b1010101011);
    for (int s = 0; s < 4; s++) send(2'd0, 8'h00, 2'(s), 4'h0);

    send_known(2'd1, 8'h00, 2'b00, 4'h0, 10'b0100000000);
    send_known(2'd1, 8'h00, 2'b00, 4'h0, 10'b1111111111);
    send(2'd0, 8'h00, 2'b00, 4'h0);
    send_known(2'd1, 8'hFF, 2'b00, 4'h0, 10'b1000000000);

    for (int c = 0; c < 16; c++) send(2'd2, 8'h00, 2'b00, 4'(c));
    send_known(2'd2, 8'h00, 2'b00, 4'h5, 10'b0100011110);
    send(2'd3, 8'h00, 2'b00, 4'h0);
    send(2'd3, 8'h00, 2'b00, 4'h0);
    send_known(2'd1, 8'h00, 2'b00, 4'h0, 10'b0100000000);

    repeat (200) send(2'd1, 8'($urandom_range(0, 255)), 2'b00, 4'h0);

    repeat (300) begin
      r = $urandom_range(0, 9);
      case (r)
        0: send(2'd0, 8'h00, 2'($urandom_range(0, 3)), 4'h0);
        1: send(2'd2, 8'h00, 2'b00, 4'($urandom_range(0, 15)));
        2: send(2'd3, 8'h00, 2'b00, 4'h0);
        3: send(2'd1, ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00, 2'b00, 4'h0);
        default: send(2'd1, 8'($urandom_range(0, 255)), 2'b00, 4'h0);
      endcase
    end

    repeat (5) send(2'd1, 8'($urandom_range(0, 255)), 2'b00, 4'h0);
    send(2'd0, 8'h00, 2'b01, 4'h0);
    send_known(2'd1, 8'h00, 2'b00, 4'h0, 10'b0100000000);
    repeat (10) send(2'd1, 8'($urandom_range(0, 255)), 2'b00, 4'h0);

    repeat (7) send(2'd1, 8'($urandom_range(0, 255)), 2'b00, 4'h0);
    pulse_reset(2);
    send_known(2'd1, 8'hFF, 2'b00, 4'h0, 10'b1000000000);
    repeat (20) send(2'd1, 8'($urandom_range(0, 255)), 2'b00, 4'h0);

    @(negedge clk);
    stim_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: %0d expected symbols never appeared, required 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
